// File: rtl/assoc_mem_argmin.sv
// Associative-memory argmin: accumulates Hamming distances per class over one or more passes
// and reports the nearest class. Define ASSOC_MEM_ARGMIN_MARGIN_EN for runner-up/margin outputs.
module assoc_mem_argmin #(
  parameter int HVDimension      = 512,
  parameter int NumClasses       = 32,
  parameter int DataWidth        = 8,
  parameter int CompareRegsWidth = 16,
  parameter int ExtCounterWidth  = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [HVDimension-1:0]      query_hv_i,
  input  logic                        am_start_i,
  output logic                        am_busy_o,
  output logic                        am_stall_o,
  input  logic [HVDimension-1:0]      class_hv_i,
  input  logic                        class_hv_valid_i,
  output logic                        class_hv_ready_o,
  input  logic                        extend_enable_i,
  input  logic [ExtCounterWidth-1:0]  extend_count_i,
  input  logic [DataWidth-1:0]        am_num_class_i,
  input  logic [CompareRegsWidth-1:0] margin_thresh_i,
  output logic [DataWidth-1:0]        predict_o,
  output logic [CompareRegsWidth-1:0] predict_dist_o,
  output logic [CompareRegsWidth-1:0] predict_margin_o,
  output logic                        predict_low_conf_o,
  output logic                        predict_valid_o,
  input  logic                        predict_ready_i,
  output logic                        am_predict_valid_o,
  input  logic                        am_predict_valid_clr_i,
  output logic                        predict_overrun_o,
  output logic                        config_err_o
);

  localparam int DistW = $clog2(HVDimension + 1);
  localparam int SumW  = ((DistW > CompareRegsWidth) ? DistW : CompareRegsWidth) + 1;
  localparam logic [CompareRegsWidth-1:0] MaxVal = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                      r_state;
  logic [DataWidth-1:0]        r_num;
  logic [DataWidth-1:0]        r_cls;
  logic [ExtCounterWidth-1:0]  r_passes;
  logic [ExtCounterWidth-1:0]  r_pass;
  logic [CompareRegsWidth-1:0] r_acc [NumClasses];
  logic [CompareRegsWidth-1:0] r_min;
  logic [DataWidth-1:0]        r_idx;
  logic [DataWidth-1:0]        r_predict;
  logic [CompareRegsWidth-1:0] r_dist;
  logic                        r_pvalid, r_am_valid, r_overrun, r_cfg_err;

  logic [HVDimension-1:0]      w_xor;
  logic [DistW-1:0]            w_dist;
  logic [CompareRegsWidth-1:0] w_acc_rd, w_final, w_min_nxt;
  logic [SumW-1:0]             w_sum;
  logic [DataWidth-1:0]        w_idx_nxt;
  logic [ExtCounterWidth-1:0]  w_ext_eff, w_passes_in;
  logic                        w_new_min, w_hs, w_last_cls, w_final_pass, w_done;
  logic                        w_cfg_bad, w_accept;

  assign w_xor = query_hv_i ^ class_hv_i;
  always_comb begin
    w_dist = '0;
    for (int i = 0; i < HVDimension; i++) w_dist = w_dist + DistW'(w_xor[i]);
  end

  // Saturating add in a width wide enough for both operands, clamped to the accumulator range.
  assign w_acc_rd = r_acc[r_cls];
  assign w_sum    = SumW'(w_dist) + SumW'(w_acc_rd);
  assign w_final  = (w_sum > SumW'(MaxVal)) ? MaxVal : w_sum[CompareRegsWidth-1:0];

  assign w_hs         = (r_state == BUSY) && class_hv_valid_i;
  assign w_last_cls   = (r_cls == r_num - DataWidth'(1));
  assign w_final_pass = (r_pass == r_passes - ExtCounterWidth'(1));
  assign w_done       = w_hs && w_last_cls && w_final_pass;

  assign w_ext_eff   = (extend_count_i == '0) ? ExtCounterWidth'(1) : extend_count_i;
  assign w_passes_in = extend_enable_i ? w_ext_eff : ExtCounterWidth'(1);
  assign w_cfg_bad   = (am_num_class_i == '0) || (32'(am_num_class_i) > NumClasses);
  assign w_accept    = (r_state == IDLE) && am_start_i && !w_cfg_bad;

  // Class 0 of the final pass seeds the running minimum; strict < keeps the lowest index on ties.
  always_comb begin
    w_min_nxt = r_min;
    w_idx_nxt = r_idx;
    w_new_min = 1'b0;
    if (r_cls == '0) begin
      w_min_nxt = w_final;
      w_idx_nxt = '0;
      w_new_min = 1'b1;
    end else if (w_final < r_min) begin
      w_min_nxt = w_final;
      w_idx_nxt = r_cls;
      w_new_min = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_num      <= '0;
      r_cls      <= '0;
      r_passes   <= '0;
      r_pass     <= '0;
      r_min      <= '0;
      r_idx      <= '0;
      r_predict  <= '0;
      r_dist     <= '0;
      r_pvalid   <= 1'b0;
      r_am_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_cfg_err  <= 1'b0;
      for (int i = 0; i < NumClasses; i++) r_acc[i] <= '0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (am_start_i && w_cfg_bad) begin
            r_cfg_err <= 1'b1;
          end else if (w_accept) begin
            r_num    <= am_num_class_i;
            r_passes <= w_passes_in;
            r_cls    <= '0;
            r_pass   <= '0;
            r_state  <= BUSY;
            for (int i = 0; i < NumClasses; i++) r_acc[i] <= '0;
          end
        end
        BUSY: begin
          if (w_hs) begin
            r_acc[r_cls] <= w_final;
            if (w_final_pass) begin
              r_min <= w_min_nxt;
              r_idx <= w_idx_nxt;
            end
            if (w_last_cls) begin
              r_cls  <= '0;
              r_pass <= r_pass + ExtCounterWidth'(1);
              if (w_final_pass) r_state <= IDLE;
            end else begin
              r_cls <= r_cls + DataWidth'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_done) begin
        r_predict <= w_idx_nxt;
        r_dist    <= w_min_nxt;
      end

      // Clear wins over a same-cycle result for the flags only; the result itself still loads.
      if (am_predict_valid_clr_i) begin
        r_pvalid   <= 1'b0;
        r_am_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end else if (w_done) begin
        r_pvalid   <= 1'b1;
        r_am_valid <= 1'b1;
        if (r_pvalid && !predict_ready_i) r_overrun <= 1'b1;
      end else if (predict_ready_i) begin
        r_pvalid <= 1'b0;
      end
    end
  end

`ifdef ASSOC_MEM_ARGMIN_MARGIN_EN
  logic [CompareRegsWidth-1:0] r_sec, r_thresh, r_margin;
  logic                        r_low_conf;
  logic [CompareRegsWidth-1:0] w_sec_nxt, w_margin;

  always_comb begin
    w_sec_nxt = r_sec;
    if (r_cls == '0)             w_sec_nxt = '1;
    else if (w_new_min)          w_sec_nxt = r_min;
    else if (w_final < r_sec)    w_sec_nxt = w_final;
  end

  // A single class has no runner-up, so the margin is reported as all-ones.
  assign w_margin = (r_num == DataWidth'(1)) ? '1 : (w_sec_nxt - w_min_nxt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sec      <= '0;
      r_thresh   <= '0;
      r_margin   <= '0;
      r_low_conf <= 1'b0;
    end else begin
      if (w_accept) r_thresh <= margin_thresh_i;
      if (w_hs && w_final_pass) r_sec <= w_sec_nxt;
      if (w_done) begin
        r_margin   <= w_margin;
        r_low_conf <= (w_margin < r_thresh);
      end
    end
  end

  assign predict_margin_o   = r_margin;
  assign predict_low_conf_o = r_low_conf;
`else
  logic w_unused;
  assign w_unused           = ^margin_thresh_i ^ w_new_min;
  assign predict_margin_o   = '0;
  assign predict_low_conf_o = 1'b0;
`endif

  assign am_busy_o          = (r_state == BUSY);
  assign class_hv_ready_o   = (r_state == BUSY);
  assign am_stall_o         = (r_state == BUSY) && am_start_i;
  assign predict_o          = r_predict;
  assign predict_dist_o     = r_dist;
  assign predict_valid_o    = r_pvalid;
  assign am_predict_valid_o = r_am_valid;
  assign predict_overrun_o  = r_overrun;
  assign config_err_o       = r_cfg_err;

endmodule

// File: doc/assoc_mem_argmin.md
ASSOC_MEM_ARGMIN -- requirements
Module: assoc_mem_argmin

Interface
REQ-001 SHALL have parameter HVDimension, default 512, hypervector width in bits.
REQ-002 SHALL have parameter NumClasses, default 32, depth of the distance accumulators (2..256).
REQ-003 SHALL have parameter DataWidth, default 8, class-index and class-count width (2^DataWidth >= NumClasses).
REQ-004 SHALL have parameter CompareRegsWidth, default 16, accumulator/distance width.
REQ-005 SHALL have parameter ExtCounterWidth, default 5, extension-pass count width.
REQ-006 SHALL have ports: clk_i input 1, sole clock; rst_i input 1, reset, asynchronous, active-high.
REQ-007 SHALL have ports: query_hv_i in HVDimension, query HV; am_start_i in 1, start request; am_busy_o out 1, busy; am_stall_o out 1, start refused.
REQ-008 SHALL have ports: class_hv_i in HVDimension, class HV; class_hv_valid_i in 1; class_hv_ready_o out 1.
REQ-009 SHALL have ports: extend_enable_i in 1; extend_count_i in ExtCounterWidth, pass count; am_num_class_i in DataWidth, active classes; margin_thresh_i in CompareRegsWidth, confidence threshold.
REQ-010 SHALL have ports: predict_o out DataWidth, winning class; predict_dist_o out CompareRegsWidth, winning distance; predict_margin_o out CompareRegsWidth, runner-up minus winner; predict_low_conf_o out 1.
REQ-011 SHALL have ports: predict_valid_o out 1; predict_ready_i in 1; am_predict_valid_o out 1, sticky CSR valid; am_predict_valid_clr_i in 1; predict_overrun_o out 1, sticky; config_err_o out 1, one-cycle pulse.

Function
REQ-012 SHALL implement FSM IDLE/BUSY; am_busy_o = class_hv_ready_o = (state==BUSY); am_stall_o = BUSY and am_start_i.
REQ-013 SHALL, in IDLE with am_start_i, latch am_num_class_i, extend_enable_i, extend_count_i, margin_thresh_i, clear all accumulators to 0 and class/pass counters to 0, enter BUSY next cycle.
REQ-014 SHALL treat passes = extend_enable ? max(extend_count,1) : 1, using latched values only; input changes during BUSY have no effect.
REQ-015 SHALL reject start when am_num_class_i==0 or >NumClasses: stay IDLE, pulse config_err_o one cycle, leave results untouched.
REQ-016 SHALL compute Hamming distance of query_hv_i vs class_hv_i combinationally (team ham_dist unit) on each accepted handshake (valid & ready).
REQ-017 SHALL add distance into accumulator[class counter] with saturation at 2^CompareRegsWidth-1 (no wrap); class counter increments per handshake, wraps to 0 after num_class-1 and advances pass counter.
REQ-018 SHALL, during the final pass, track running minimum and runner-up over final values (acc+dist) as each class arrives; strict less-than, so ties resolve to lowest index; no comparison tree.
REQ-019 SHALL, on the final handshake of the final pass, return to IDLE and register predict_o, predict_dist_o, predict_margin_o the next cycle (latency 1 cycle); predict_valid_o and am_predict_valid_o rise that same cycle.
REQ-020 SHALL, with num_class==1, report class 0, margin all-ones.
REQ-021 SHALL hold predict_valid_o until predict_ready_i or am_predict_valid_clr_i; am_predict_valid_o holds until am_predict_valid_clr_i only.
REQ-022 SHALL, if a new result registers while predict_valid_o is high and predict_ready_i is low, overwrite result and set predict_overrun_o until am_predict_valid_clr_i.
REQ-023 SHALL give am_predict_valid_clr_i priority over a same-cycle new result for the valid flags (flags cleared, result still registered).
REQ-024 SHALL accept am_start_i in the same cycle the previous job's result registers (back-to-back).

Reset
REQ-025 SHALL, on rst_i asserted (including mid-job), go IDLE; clear counters, accumulators, predict_o, predict_dist_o, predict_margin_o, predict_low_conf_o, all valid/overrun/error flags to 0.
REQ-026 SHALL drive class_hv_ready_o 0 during reset and the first cycle after release.

Configuration
REQ-027 SHALL use macro ASSOC_MEM_ARGMIN_MARGIN_EN: defined -> runner-up tracking, predict_margin_o, predict_low_conf_o = (margin < latched threshold); undefined -> no runner-up logic, predict_margin_o and predict_low_conf_o tied 0, margin_thresh_i ignored.

Verification
REQ-028 SHALL cover: 4 classes, 1 pass, distances 100,40,70,40 -> predict_o=1, dist=40, margin=0, low_conf=1 (thresh 5), valid 1 cycle after 4th handshake.
REQ-029 SHALL cover: extend_enable=1, count=3, 2 classes, per-pass distances (10,20),(30,5),(5,30) -> dist 45 vs 55, predict_o=0, margin=10.
REQ-030 SHALL cover: CompareRegsWidth=8, 3 passes of 200 on class 0 -> accumulator saturates 255, class 1 at 254 wins.
REQ-031 SHALL cover: am_num_class_i=0 and =NumClasses+1 -> config_err_o pulse, busy stays 0; start while BUSY -> am_stall_o=1, job unaffected.
REQ-032 SHALL cover: second result with predict_ready_i=0 -> overrun=1, predict_o updated; clr -> all valid/overrun 0.
REQ-033 SHALL cover: rst_i mid-pass after 2 handshakes -> all outputs 0, next job correct from clean state.
